// File: rtl/idct_pkg.sv
// Shared constants and helpers for the 8x8 inverse DCT: basis table, FSM
// state codes, derived widths and output saturation.
package idct_pkg;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ROW  = 2'd1;
   localparam logic [1:0] S_COL  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   // T[n][k] = round(4096 * c(k) * cos((2n+1)k*pi/16)); n = spatial, k = frequency
   localparam logic signed [12:0] T_TAB [8][8] = '{
      '{13'sd2896,  13'sd4017,  13'sd3784,  13'sd3406,  13'sd2896,  13'sd2276,  13'sd1567,  13'sd799},
      '{13'sd2896,  13'sd3406,  13'sd1567, -13'sd799,  -13'sd2896, -13'sd4017, -13'sd3784, -13'sd2276},
      '{13'sd2896,  13'sd2276, -13'sd1567, -13'sd4017, -13'sd2896,  13'sd799,   13'sd3784,  13'sd3406},
      '{13'sd2896,  13'sd799,  -13'sd3784, -13'sd2276,  13'sd2896,  13'sd3406, -13'sd1567, -13'sd4017},
      '{13'sd2896, -13'sd799,  -13'sd3784,  13'sd2276,  13'sd2896, -13'sd3406, -13'sd1567,  13'sd4017},
      '{13'sd2896, -13'sd2276, -13'sd1567,  13'sd4017, -13'sd2896, -13'sd799,   13'sd3784, -13'sd3406},
      '{13'sd2896, -13'sd3406,  13'sd1567,  13'sd799,  -13'sd2896,  13'sd4017, -13'sd3784,  13'sd2276},
      '{13'sd2896, -13'sd4017,  13'sd3784, -13'sd3406,  13'sd2896, -13'sd2276,  13'sd1567, -13'sd799}
   };

   // Intermediate keeps 3 fractional bits on top of the coefficient range
   function automatic int iw_of(input int cw);
      return cw + 6;
   endfunction

   function automatic int acc_w(input int in_w);
      return in_w + 16;
   endfunction

   function automatic logic [7:0] sat_u8(input logic signed [31:0] v);
      if (v < 0)
         return 8'd0;
      if (v > 32'sd255)
         return 8'd255;
      return v[7:0];
   endfunction

endpackage

// File: rtl/idct8_1d.sv
// Combinational 8-point 1-D IDCT with round-half-up; the shift is chosen per
// pass so one instance serves both the row and the column pass.
module idct8_1d
   import idct_pkg::*;
#(
   parameter int IN_W    = 18,
   parameter int SHIFT_A = 10,
   parameter int SHIFT_B = 16
) (
   input  logic                   sel_b,
   input  logic signed [IN_W-1:0] x [8],
   output logic signed [IN_W-1:0] y [8]
);

   localparam int AW = acc_w(IN_W);
   localparam logic signed [AW-1:0] HALF_A = AW'(1) <<< (SHIFT_A - 1);
   localparam logic signed [AW-1:0] HALF_B = AW'(1) <<< (SHIFT_B - 1);

   // Arithmetic shift floors, so adding half first gives round-half-up
   function automatic logic signed [IN_W-1:0] round_shift(input logic signed [AW-1:0] a,
                                                         input logic b);
      logic signed [AW-1:0] r;
      r = b ? (a + HALF_B) >>> SHIFT_B : (a + HALF_A) >>> SHIFT_A;
      return r[IN_W-1:0];
   endfunction

   logic signed [AW-1:0] acc [8];

   always_comb begin
      for (int n = 0; n < 8; n++) begin
         acc[n] = '0;
         for (int k = 0; k < 8; k++)
            acc[n] = acc[n] + AW'(T_TAB[n][k]) * AW'(x[k]);
         y[n] = round_shift(acc[n], sel_b);
      end
   end

endmodule

// File: rtl/two_d_idct.sv
// 8x8 inverse DCT by row-column decomposition: eight row cycles into the
// transpose buffer, eight column cycles into the pixel register.
module two_d_idct
   import idct_pkg::*;
#(
   parameter int CW          = 12,
   parameter int LEVEL_SHIFT = 128
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic signed [63:0][CW-1:0] coef,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic        [63:0][7:0]    pixel
);

   localparam int IW = iw_of(CW);

   logic [1:0]           state;
   logic [2:0]           cnt;
   logic [63:0][CW-1:0]  coef_buf;
   logic signed [IW-1:0] tbuf [8][8];
   logic signed [IW-1:0] x [8];
   logic signed [IW-1:0] y [8];
   logic [7:0]           pix [8];
   logic                 accept;
   logic                 last;
   logic                 col_pass;

   assign in_ready  = (state == S_IDLE);
   assign out_valid = (state == S_DONE);
   assign accept    = in_valid && in_ready;
   assign last      = (cnt == 3'd7);
   assign col_pass  = (state == S_COL);

   // Row pass reads coefficient row cnt; column pass reads transpose column cnt
   always_comb begin
      for (int k = 0; k < 8; k++) begin
         if (state == S_ROW)
            x[k] = IW'($signed(coef_buf[{cnt, 3'(k)}]));
         else
            x[k] = tbuf[k][cnt];
      end
   end

   idct8_1d #(
      .IN_W   (IW),
      .SHIFT_A(10),
      .SHIFT_B(16)
   ) u_idct (
      .sel_b(col_pass),
      .x    (x),
      .y    (y)
   );

   always_comb begin
      for (int n = 0; n < 8; n++)
         pix[n] = sat_u8(32'(y[n]) + 32'(LEVEL_SHIFT));
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
         cnt   <= '0;
         pixel <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  state <= S_ROW;
                  cnt   <= '0;
               end
            end
            S_ROW: begin
               cnt <= cnt + 3'd1;
               if (last)
                  state <= S_COL;
            end
            S_COL: begin
               for (int n = 0; n < 8; n++)
                  pixel[{3'(n), cnt}] <= pix[n];
               cnt <= cnt + 3'd1;
               if (last)
                  state <= S_DONE;
            end
            S_DONE: begin
               if (out_ready)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Data storage carries no reset; it is always rewritten before being read
   always_ff @(posedge clock) begin
      if (accept)
         coef_buf <= coef;
      if (state == S_ROW) begin
         for (int n = 0; n < 8; n++)
            tbuf[cnt][n] <= y[n];
      end
   end

endmodule

// File: tb/tb_two_d_idct.sv
// Bench for two_d_idct: directed and random blocks against a floating-point
// derived reference, with handshake, latency, back-pressure and reset checks.
module tb_two_d_idct;

   localparam int CW = 12;

   logic                       clock = 1'b0;
   logic                       reset = 1'b1;
   logic                       in_valid = 1'b0;
   logic                       in_ready;
   logic signed [63:0][CW-1:0] coef = '0;
   logic                       out_valid;
   logic                       out_ready = 1'b0;
   logic        [63:0][7:0]    pixel;
   logic        [63:0][7:0]    snap;

   int checks = 0;
   int errors = 0;
   int tm [8][8];
   int cf_m [64];
   int px_m [64];
   int lat;
   int nz;

   always #5 clock = ~clock;

   two_d_idct #(
      .CW         (CW),
      .LEVEL_SHIFT(128)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .coef     (coef),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .pixel    (pixel)
   );

   initial begin
      #300000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic int rnd(input real v);
      if (v >= 0.0)
         return $rtoi(v + 0.5);
      return -$rtoi(-v + 0.5);
   endfunction

   task automatic build_table();
      real pi, ck;
      pi = 3.14159265358979323846;
      for (int n = 0; n < 8; n++)
         for (int k = 0; k < 8; k++) begin
            ck = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
            tm[n][k] = rnd(8192.0 * 0.5 * ck * $cos(real'((2 * n + 1) * k) * pi / 16.0));
         end
   endtask

   // Separable inverse transform with the documented rounding at each pass
   task automatic model();
      longint t [8][8];
      longint acc;
      longint s;
      for (int r = 0; r < 8; r++)
         for (int j = 0; j < 8; j++) begin
            acc = 0;
            for (int k = 0; k < 8; k++)
               acc += longint'(tm[j][k]) * longint'(cf_m[8 * r + k]);
            t[r][j] = (acc + 512) >>> 10;
         end
      for (int c = 0; c < 8; c++)
         for (int i = 0; i < 8; i++) begin
            acc = 0;
            for (int u = 0; u < 8; u++)
               acc += longint'(tm[i][u]) * t[u][c];
            s = ((acc + 32768) >>> 16) + 128;
            px_m[8 * i + c] = (s < 0) ? 0 : (s > 255) ? 255 : int'(s);
         end
   endtask

   task automatic clear_coef();
      for (int i = 0; i < 64; i++)
         cf_m[i] = 0;
   endtask

   task automatic random_coef(input bit sparse);
      for (int i = 0; i < 64; i++) begin
         if (sparse)
            cf_m[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) - 128 : 0;
         else
            cf_m[i] = int'($urandom_range(0, 4095)) - 2048;
      end
   endtask

   task automatic offer();
      for (int i = 0; i < 64; i++)
         coef[i] = 12'(cf_m[i]);
      model();
      in_valid = 1'b1;
   endtask

   task automatic accept(input string tag);
      int n;
      n = 0;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      check({tag, "_ready"}, in_ready, 1);
      tick();
      in_valid = 1'b0;
      check({tag, "_busy"}, in_ready, 0);
   endtask

   task automatic wait_done(input string tag);
      lat = 0;
      while (!out_valid && lat < 40) begin
         tick();
         lat++;
      end
      check({tag, "_latency"}, lat, 16);
   endtask

   task automatic check_pixels(input string tag);
      for (int i = 0; i < 64; i++)
         check($sformatf("%s_pix%0d", tag, i), pixel[i], px_m[i]);
   endtask

   task automatic release_out(input string tag);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, "_idle_ready"}, in_ready, 1);
      check({tag, "_idle_valid"}, out_valid, 0);
   endtask

   task automatic count_nonzero();
      nz = 0;
      for (int i = 0; i < 64; i++)
         if (pixel[i] !== 8'd0)
            nz++;
   endtask

   initial begin
      build_table();

      // Reset state
      #12;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      count_nonzero();
      check("rst_pixel_nonzero", nz, 0);
      @(negedge clock);
      reset = 1'b0;
      tick();

      // DC only
      clear_coef();
      cf_m[0] = 64;
      offer();
      accept("dc64");
      wait_done("dc64");
      check_pixels("dc64");
      check("dc64_p0", pixel[0], 136);
      check("dc64_p63", pixel[63], 136);
      release_out("dc64");

      // All zero, then a back-to-back block with out_ready held high
      clear_coef();
      offer();
      accept("zero");
      out_ready = 1'b1;
      wait_done("zero");
      check_pixels("zero");
      check("zero_p9", pixel[9], 128);
      clear_coef();
      cf_m[1] = 100;
      offer();
      check("gap_done_ready", in_ready, 0);
      tick();
      check("gap_idle_ready", in_ready, 1);
      tick();
      check("gap_accept_busy", in_ready, 0);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      wait_done("h1");
      check_pixels("h1");
      for (int i = 0; i < 8; i++) begin
         check($sformatf("h1_row%0d_c0", i), pixel[8 * i], 145);
         check($sformatf("h1_row%0d_c7", i), pixel[8 * i + 7], 111);
      end
      release_out("h1");

      // Saturation at both extremes
      for (int s = 0; s < 2; s++) begin
         clear_coef();
         cf_m[0] = (s == 0) ? 2047 : -2048;
         offer();
         accept("sat");
         wait_done("sat");
         check_pixels($sformatf("sat%0d", s));
         check($sformatf("sat%0d_p0", s), pixel[0], (s == 0) ? 255 : 0);
         check($sformatf("sat%0d_p63", s), pixel[63], (s == 0) ? 255 : 0);
         release_out("sat");
      end

      // Back-pressure in DONE while new data is offered
      random_coef(1'b1);
      offer();
      accept("bp");
      wait_done("bp");
      check_pixels("bp");
      snap = pixel;
      for (int w = 0; w < 5; w++) begin
         in_valid = ~in_valid;
         for (int i = 0; i < 64; i++)
            coef[i] = 12'($urandom_range(0, 4095));
         tick();
         check($sformatf("bp_hold%0d_ready", w), in_ready, 0);
         check($sformatf("bp_hold%0d_valid", w), out_valid, 1);
         nz = 0;
         for (int i = 0; i < 64; i++)
            if (pixel[i] !== snap[i])
               nz++;
         check($sformatf("bp_hold%0d_changed", w), nz, 0);
      end
      in_valid = 1'b0;
      release_out("bp");

      // Random blocks, alternating full-range and sparse small values
      for (int b = 0; b < 6; b++) begin
         random_coef(b[0]);
         offer();
         accept("rnd");
         wait_done("rnd");
         check_pixels($sformatf("rnd%0d", b));
         release_out("rnd");
      end

      // Reset in the middle of the row pass
      random_coef(1'b0);
      offer();
      accept("mid");
      for (int w = 0; w < 4; w++)
         tick();
      #2;
      reset = 1'b1;
      #1;
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_ready", in_ready, 1);
      count_nonzero();
      check("mid_rst_pixel_nonzero", nz, 0);
      @(negedge clock);
      reset = 1'b0;
      tick();
      clear_coef();
      cf_m[0] = 64;
      offer();
      accept("post");
      wait_done("post");
      check_pixels("post");
      check("post_p36", pixel[36], 136);
      release_out("post");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
